// File: rtl/hello_pkg.sv
// rtl/hello_pkg.sv - message ROM, sizing and UART state enum for hello_msg_tx; HELLO_MSG_CRLF_EN appends CR LF
package hello_pkg;

`ifdef HELLO_MSG_CRLF_EN
  localparam int MSG_LEN = 13;
  localparam logic [7:0] MSG [MSG_LEN] = '{
    8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
    8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0D, 8'h0A
  };
`else
  localparam int MSG_LEN = 11;
  localparam logic [7:0] MSG [MSG_LEN] = '{
    8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
    8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64
  };
`endif

  localparam int BYTE_IDX_W = $clog2(MSG_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Out-of-range indices (idx == MSG_LEN) read as zero; the byte is never sent then.
  function automatic logic [7:0] msg_byte(input logic [BYTE_IDX_W-1:0] idx);
    msg_byte = 8'h00;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (idx == BYTE_IDX_W'(i)) msg_byte = MSG[i];
    end
  endfunction

endpackage

// File: rtl/hello_msg_tx_if.sv
// rtl/hello_msg_tx_if.sv - start/tx/busy/sent bundle; master drives start, slave is the transmitter
interface hello_msg_tx_if;
  logic start;
  logic tx;
  logic busy;
  logic sent;

  modport master (output start, input tx, input busy, input sent);
  modport slave  (input start, output tx, output busy, output sent);
endinterface

// File: rtl/hello_msg_tx_uart_tx_byte.sv
// rtl/hello_msg_tx_uart_tx_byte.sv - 8N1 LSB-first byte serializer with valid/ready and flopped tx
module uart_tx_byte
  import hello_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       done,
  output logic       tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             tx_q, tx_d;
  logic             tc;

  assign tc = (cnt_q == CNT_LAST);
  assign tx = tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  // ready is also high at the end of STOP so the next start bit follows with no idle gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        tx_d  = 1'b1;
        if (valid) begin
          state_d = START;
          cnt_d   = '0;
          sh_d    = data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tc) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tc) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end
      end
      STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tc) begin
          ready = 1'b1;
          done  = 1'b1;
          cnt_d = '0;
          if (valid) begin
            state_d = START;
            sh_d    = data;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/hello_msg_tx.sv
// rtl/hello_msg_tx.sv - sends "Hello World" (plus CR LF under HELLO_MSG_CRLF_EN) over UART on a start rising edge
module hello_msg_tx
  import hello_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input logic           clk,
  input logic           rst,
  hello_msg_tx_if.slave bus
);

  logic                  start_q;
  logic                  busy_q;
  logic                  sent_q;
  logic [BYTE_IDX_W-1:0] byte_idx_q;

  logic       trigger;
  logic       more;
  logic       valid;
  logic       ready;
  logic       frame_done;
  logic       accept;
  logic       last_done;
  logic [7:0] data;
  logic       tx_w;

  // Not busy is the message-level idle state; edges while busy are dropped, not queued.
  assign trigger   = bus.start & ~start_q & ~busy_q;
  assign more      = (byte_idx_q != BYTE_IDX_W'(MSG_LEN));
  assign valid     = trigger | (busy_q & more);
  assign data      = msg_byte(busy_q ? byte_idx_q : '0);
  assign accept    = valid & ready;
  assign last_done = busy_q & frame_done & ~more;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
      byte_idx_q <= '0;
    end else begin
      start_q <= bus.start;
      sent_q  <= last_done;
      if (trigger) begin
        busy_q     <= 1'b1;
        byte_idx_q <= BYTE_IDX_W'(1);
      end else if (accept) begin
        byte_idx_q <= byte_idx_q + BYTE_IDX_W'(1);
      end
      if (last_done) busy_q <= 1'b0;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .data  (data),
    .ready (ready),
    .done  (frame_done),
    .tx    (tx_w)
  );

  assign bus.tx   = tx_w;
  assign bus.busy = busy_q;
  assign bus.sent = sent_q;

endmodule

// File: tb/tb_hello_msg_tx.sv
// tb/tb_hello_msg_tx.sv - scoreboard bench for hello_msg_tx with a UART decoder on tx
module tb_hello_msg_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst;

  hello_msg_tx_if bus_if ();

  hello_msg_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] msg    [$];
  logic [7:0] exp_q  [$];
  int         fstart_q [$];

  int         cyc = 0;
  int         sent_cnt = 0;
  int         sent_busy_bad = 0;
  int         busy_run = 0;
  int         last_busy_len = 0;
  int         m_t = 0;
  bit         m_active = 1'b0;
  logic [7:0] m_sh = 8'h00;

  always @(posedge clk) cyc++;

  // Decoder: samples mid-bit on negedges; each decoded byte is popped against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      busy_run = 0;
    end else begin
      if (bus_if.sent === 1'b1) begin
        sent_cnt++;
        if (bus_if.busy !== 1'b0) sent_busy_bad++;
      end
      if (bus_if.busy === 1'b1) busy_run++;
      else if (busy_run != 0) begin
        last_busy_len = busy_run;
        busy_run = 0;
      end
      if (!m_active) begin
        if (bus_if.tx === 1'b0) begin
          m_active = 1'b1;
          m_t = 0;
          fstart_q.push_back(cyc);
        end
      end else begin
        m_t++;
      end
      if (m_active) begin
        if (m_t >= 5 && m_t <= 33 && (m_t % 4) == 1) m_sh = {bus_if.tx, m_sh[7:1]};
        if (m_t == 37) begin
          n_checks++;
          if (bus_if.tx !== 1'b1) $display("FAIL stop_bit got %b want 1", bus_if.tx);
          else n_pass++;
        end
        if (m_t == 39) begin
          m_active = 1'b0;
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL rx_byte got %h want no byte", m_sh);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (m_sh !== e) $display("FAIL rx_byte got %h want %h", m_sh, e);
            else n_pass++;
          end
        end
      end
    end
  end

  task automatic push_msg();
    foreach (msg[i]) exp_q.push_back(msg[i]);
  endtask

  task automatic wait_idle(output bit timeout);
    int n;
    n = 0;
    while (bus_if.busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    timeout = (n >= 3000);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus_if.tx !== 1'b1) $display("FAIL reset_tx got %b want 1", bus_if.tx); else n_pass++;
    n_checks++;
    if (bus_if.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus_if.busy); else n_pass++;
    n_checks++;
    if (bus_if.sent !== 1'b0) $display("FAIL reset_sent got %b want 0", bus_if.sent); else n_pass++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus_if.tx !== 1'b1) $display("FAIL idle_tx got %b want 1", bus_if.tx); else n_pass++;
  endtask

  task automatic test_first_message();
    logic [9:0] fr;
    int s0, bad, n;
    bit to;
    fr = {1'b1, 8'h48, 1'b0};
    s0 = sent_cnt;
    fstart_q.delete();
    push_msg();
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_if.busy !== 1'b1) $display("FAIL latency_busy got %b want 1", bus_if.busy); else n_pass++;
    n_checks++;
    if (bus_if.tx !== 1'b0) $display("FAIL latency_tx got %b want 0", bus_if.tx); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (bus_if.tx !== fr[i]) $display("FAIL h_bit%0d got %b want %b", i, bus_if.tx, fr[i]);
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
    end
    wait_idle(to);
    n_checks++;
    if (to) $display("FAIL first_done got busy stuck want idle"); else n_pass++;
    n_checks++;
    if (last_busy_len != msg.size() * FRAME)
      $display("FAIL busy_len got %0d want %0d", last_busy_len, msg.size() * FRAME);
    else n_pass++;
    n_checks++;
    if (sent_cnt - s0 != 1) $display("FAIL sent_pulses got %0d want 1", sent_cnt - s0); else n_pass++;
    n_checks++;
    if (sent_busy_bad != 0) $display("FAIL sent_with_busy got %0d want 0", sent_busy_bad); else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL bytes_left got %0d want 0", exp_q.size()); else n_pass++;
    bad = 0;
    for (int i = 1; i < fstart_q.size(); i++) if (fstart_q[i] - fstart_q[i-1] != FRAME) bad++;
    n_checks++;
    if (fstart_q.size() != msg.size() || bad != 0)
      $display("FAIL frames got %0d frames %0d gaps want %0d frames 0 gaps", fstart_q.size(), bad, msg.size());
    else n_pass++;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_if.busy === 1'b1) n++;
    end
    n_checks++;
    if (n != 0) $display("FAIL held_start_resend got %0d busy cycles want 0", n); else n_pass++;
  endtask

  task automatic test_ignore_during_busy();
    int s0, bad, n;
    bit to;
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);
    s0 = sent_cnt;
    fstart_q.delete();
    push_msg();
    bus_if.start = 1'b1;
    @(posedge clk);
    repeat (98) @(posedge clk);
    #1 bus_if.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus_if.start = 1'b1;
    wait_idle(to);
    n_checks++;
    if (to) $display("FAIL ignore_done got busy stuck want idle"); else n_pass++;
    n_checks++;
    if (last_busy_len != msg.size() * FRAME)
      $display("FAIL ignore_busy_len got %0d want %0d", last_busy_len, msg.size() * FRAME);
    else n_pass++;
    n_checks++;
    if (sent_cnt - s0 != 1) $display("FAIL ignore_sent got %0d want 1", sent_cnt - s0); else n_pass++;
    bad = 0;
    for (int i = 1; i < fstart_q.size(); i++) if (fstart_q[i] - fstart_q[i-1] != FRAME) bad++;
    n_checks++;
    if (fstart_q.size() != msg.size() || bad != 0 || exp_q.size() != 0)
      $display("FAIL ignore_frames got %0d frames %0d gaps %0d left want %0d frames 0 gaps 0 left",
               fstart_q.size(), bad, exp_q.size(), msg.size());
    else n_pass++;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_if.busy === 1'b1) n++;
    end
    n_checks++;
    if (n != 0) $display("FAIL queued_edge got %0d busy cycles want 0", n); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s0;
    bit to;
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk);
    s0 = sent_cnt;
    fstart_q.delete();
    push_msg();
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_if.busy !== 1'b1 || bus_if.tx !== 1'b0)
      $display("FAIL resend_start got busy=%b tx=%b want busy=1 tx=0", bus_if.busy, bus_if.tx);
    else n_pass++;
    wait_idle(to);
    n_checks++;
    if (to || exp_q.size() != 0 || sent_cnt - s0 != 1)
      $display("FAIL resend got timeout=%0d left=%0d sent=%0d want 0 0 1", to, exp_q.size(), sent_cnt - s0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int s0;
    bit to;
    bus_if.start = 1'b0;
    repeat (2) @(negedge clk);
    s0 = sent_cnt;
    exp_q.push_back(8'h48);
    bus_if.start = 1'b1;
    @(posedge clk);
    repeat (57) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus_if.tx !== 1'b1) $display("FAIL async_rst_tx got %b want 1", bus_if.tx); else n_pass++;
    n_checks++;
    if (bus_if.busy !== 1'b0) $display("FAIL async_rst_busy got %b want 0", bus_if.busy); else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL pre_rst_bytes got %0d left want 0", exp_q.size()); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sent_cnt != s0) $display("FAIL rst_sent got %0d pulses want 0", sent_cnt - s0); else n_pass++;
    fstart_q.delete();
    push_msg();
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_if.busy !== 1'b1 || bus_if.tx !== 1'b0)
      $display("FAIL restart_edge got busy=%b tx=%b want busy=1 tx=0", bus_if.busy, bus_if.tx);
    else n_pass++;
    wait_idle(to);
    n_checks++;
    if (to || exp_q.size() != 0 || sent_cnt - s0 != 1 || fstart_q.size() != msg.size())
      $display("FAIL restart got timeout=%0d left=%0d sent=%0d frames=%0d want 0 0 1 %0d",
               to, exp_q.size(), sent_cnt - s0, fstart_q.size(), msg.size());
    else n_pass++;
  endtask

  initial begin
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64};
`ifdef HELLO_MSG_CRLF_EN
    msg.push_back(8'h0D);
    msg.push_back(8'h0A);
`endif
    test_reset();
    test_first_message();
    test_ignore_during_busy();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 20000 cycles");
    $fatal(1);
  end

endmodule
